uart16550_regs: RTL and testbench
=================================

# uart16550_regs

Register file and serial core of a 16450/16550-compatible UART: the eight byte-wide registers, the baud generator, a single-character transmitter and receiver, interrupt prioritisation and modem-control logic. It sits behind a bus adapter (e.g. APB) that supplies one-cycle read/write strobes with a 3-bit register address. There is no FIFO; behaviour is 16450 (character) mode.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_addr_i  in  3  register address
- wb_dat_i  in  8  write data, sampled when wb_we_i=1
- wb_dat_o  out  8  read data, registered
- wb_we_i  in  1  one-cycle write strobe
- wb_re_i  in  1  one-cycle read strobe
- modem_inputs  in  4  {cts, dsr, ri, dcd}, active-high
- stx_pad_o  out  1  serial TX, idle 1
- srx_pad_i  in  1  serial RX, asynchronous, 2-flop synchronised
- rts_pad_o  out  1  MCR[1]
- dtr_pad_o  out  1  MCR[0]
- int_o  out  1  interrupt, = ~IIR[0]

## Operation
- Map (DLAB=LCR[7]):
  - 0: read RBR / write THR (DLAB=0); DLL (DLAB=1)
  - 1: IER[3:0] (DLAB=0); DLM (DLAB=1)
  - 2: read IIR / write FCR
  - 3: LCR; 4: MCR[4:0]; 5: LSR (read only); 6: MSR (read only); 7: SCR
- Reset: LCR=0x03, IER=0, MCR=0, SCR=0, DL=0, RBR=0, LSR=0x60, MSR[3:0]=0, IIR=0x01, wb_dat_o=0, stx_pad_o=1, int_o=0.
- FCR: bit1=1 clears DR/RBR; bit2=1 aborts pending THR (THRE=1); other bits ignored; IIR[7:6]=00 always.
- Baud: 16x tick every DL clocks when DL≠0; DL=0 stops both TX and RX; any DLL/DLM write restarts the counter.
- Frame: start(0), 5–8 data bits LSB first (LCR[1:0]+5), optional parity (LCR[3]; LCR[4]=1 even; LCR[5]=1 stick: parity = ~LCR[4]), stop 1 (LCR[2]=0) or 2. Each bit = 16 ticks. LCR[6]=1 forces stx_pad_o=0.
- TX: THR write sets THRE=0; when shifter idle, THR moves to shifter on next clock, THRE=1; TEMT=1 only when THR and shifter both empty.
- RX: falling edge starts; start rechecked at tick 8 (false start if 1); data/parity/stop sampled at tick 8 of each bit. On stop: RBR loaded, DR=1, PE/FE set per char, BI if data, parity and stop all 0. If DR already 1: OE=1, new char discarded.
- LSR: {0, TEMT, THRE, BI, FE, PE, OE, DR}. Reading LSR clears OE, PE, FE, BI. Reading RBR clears DR.
- MSR: [7:4]={dcd, ri, dsr, cts}; [0] DCTS, [1] DDSR, [2] TERI (ri 1->0), [3] DDCD; deltas sticky, cleared by MSR read.
- Loopback (MCR[4]=1): stx_pad_o=1, RX fed internally from TX; cts=MCR[1], dsr=MCR[0], ri=MCR[2], dcd=MCR[3]; rts/dtr pads driven 0.
- IIR priority: 0x06 RLS (IER[2] & (OE|PE|FE|BI)); 0x04 RDA (IER[0] & DR); 0x02 THRE (IER[1] & thre_pend); 0x00 modem (IER[3] & any delta); else 0x01.
- thre_pend: set on THRE 0->1 or IER[1] 0->1 write while THRE=1; cleared on THR write or IIR read returning 0x02.

## Timing
- Write: register updates on the edge where wb_we_i=1.
- Read: on the edge where wb_re_i=1, wb_dat_o <= selected value (pre-clear value); held until next read. Read side-effects apply on same edge.
- Simultaneous char completion and RBR read: read wins data, new char loads DR=1 (no overrun).
- Status/interrupt changes visible at int_o the clock after the causing event.
- Reset mid-frame aborts TX/RX immediately; stx_pad_o=1.

## Test plan
- Reset -> read addr 3,5,2,4 return 0x03, 0x60, 0x01, 0x00; int_o=0.
- Write SCR 0xA5, LCR 0x83, DLL 0x01, DLM 0x00, LCR 0x03 -> reads return 0xA5, DLL readback 0x01 while DLAB=1.
- DL=1, 8N1, write THR 0x55 -> stx_pad_o: 0,1,0,1,0,1,0,1,0,1 each 16 clocks; LSR 0x00 then 0x20 then 0x60.
- Loopback, IER=0x01, send 0xC3 -> LSR[0]=1, int_o=1, IIR=0x04; RBR read=0xC3, int_o=0.
- Loopback, send two chars without reading -> LSR=0x63 (OE, DR); RBR=first char; second LSR read 0x61.
- IER=0x08, modem_inputs cts 0->1 -> MSR=0x11, IIR=0x00; MSR re-read=0x10, IIR=0x01.

Source files
------------

// File: rtl/uart16550_regs.sv
// uart16550_regs: 16450-mode UART core. Holds the eight byte-wide registers,
// the 16x baud generator, a single-character transmitter and receiver,
// interrupt prioritisation and modem-control/loopback logic.
module uart16550_regs (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic [2:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_re_i,
  input  logic [3:0] modem_inputs,
  output logic       stx_pad_o,
  input  logic       srx_pad_i,
  output logic       rts_pad_o,
  output logic       dtr_pad_o,
  output logic       int_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} ser_state_e;

  // Programmer-visible registers
  logic [7:0] lcr_q, scr_q, dll_q, dlm_q, thr_q, rbr_q, dat_q;
  logic [3:0] ier_q;
  logic [4:0] mcr_q;
  logic       thr_full_q, dr_q, oe_q, pe_q, fe_q, bi_q, thre_pend_q;
  logic [3:0] mdm_q;    // {dcd, ri, dsr, cts} as last seen
  logic [3:0] delta_q;  // {ddcd, teri, ddsr, dcts}

  // Baud generator
  logic [15:0] bcnt_q, bcnt_d;
  logic        tick;

  // Transmitter
  ser_state_e  tx_state_q;
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic [3:0]  tx_tcnt_q;
  logic        tx_par_q, tx_stop2_q, tx_out_q;

  // Receiver
  ser_state_e  rx_state_q;
  logic [7:0]  rx_sh_q, rx_char_q;
  logic [2:0]  rx_bit_q;
  logic [3:0]  rx_tcnt_q;
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_par_q, rx_done_q, rx_pe_q, rx_fe_q, rx_bi_q;

  logic [7:0]  iir, lsr, msr, rd_val;

  // Width-dependent mask of the data bits in a character
  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    case (wls)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  endfunction

  // Parity bit for a character: even/odd over the data bits, or stick
  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] wls,
                                   input logic eps, input logic stick);
    if (stick) par_bit = ~eps;
    else       par_bit = (^(d & data_mask(wls))) ^ ~eps;
  endfunction

  // Bus decode
  logic dlab, loop;
  logic wr_thr, wr_dll, wr_dlm, wr_ier, wr_fcr, wr_lcr, wr_mcr, wr_scr;
  logic rd_rbr, rd_iir, rd_lsr, rd_msr;
  assign dlab   = lcr_q[7];
  assign loop   = mcr_q[4];
  assign wr_thr = wb_we_i && wb_addr_i == 3'd0 && !dlab;
  assign wr_dll = wb_we_i && wb_addr_i == 3'd0 && dlab;
  assign wr_dlm = wb_we_i && wb_addr_i == 3'd1 && dlab;
  assign wr_ier = wb_we_i && wb_addr_i == 3'd1 && !dlab;
  assign wr_fcr = wb_we_i && wb_addr_i == 3'd2;
  assign wr_lcr = wb_we_i && wb_addr_i == 3'd3;
  assign wr_mcr = wb_we_i && wb_addr_i == 3'd4;
  assign wr_scr = wb_we_i && wb_addr_i == 3'd7;
  assign rd_rbr = wb_re_i && wb_addr_i == 3'd0 && !dlab;
  assign rd_iir = wb_re_i && wb_addr_i == 3'd2;
  assign rd_lsr = wb_re_i && wb_addr_i == 3'd5;
  assign rd_msr = wb_re_i && wb_addr_i == 3'd6;

  logic [15:0] dl;
  logic        dl_nz, fcr_clr, fcr_abort, tx_load, thre_rise, rx_accept;
  logic [2:0]  last_bit;
  assign dl        = {dlm_q, dll_q};
  assign dl_nz     = |dl;
  assign last_bit  = 3'd4 + {1'b0, lcr_q[1:0]};
  assign fcr_clr   = wr_fcr & wb_dat_i[1];
  assign fcr_abort = wr_fcr & wb_dat_i[2];
  assign tx_load   = thr_full_q && tx_state_q == S_IDLE;
  assign thre_rise = thr_full_q & ~wr_thr & (tx_load | fcr_abort);
  assign rx_accept = ~dr_q | rd_rbr | fcr_clr;

  // Serial line routing; loopback keeps the pad idle and feeds RX from TX
  logic tx_line, rx_in;
  assign tx_line   = ~lcr_q[6] & tx_out_q;
  assign stx_pad_o = loop | tx_line;
  assign rx_in     = loop ? tx_line : rx_sync_q[1];
  assign rts_pad_o = mcr_q[1] & ~loop;
  assign dtr_pad_o = mcr_q[0] & ~loop;

  // Modem status source and change detection
  logic [3:0] mdm_cur, new_delta;
  assign mdm_cur   = loop ? {mcr_q[3], mcr_q[2], mcr_q[0], mcr_q[1]}
                          : {modem_inputs[0], modem_inputs[1], modem_inputs[2], modem_inputs[3]};
  assign new_delta = {mdm_cur[3] ^ mdm_q[3], mdm_q[2] & ~mdm_cur[2],
                      mdm_cur[1] ^ mdm_q[1], mdm_cur[0] ^ mdm_q[0]};

  assign lsr      = {1'b0, ~thr_full_q & (tx_state_q == S_IDLE), ~thr_full_q,
                     bi_q, fe_q, pe_q, oe_q, dr_q};
  assign msr      = {mdm_q, delta_q};
  assign int_o    = ~iir[0];
  assign wb_dat_o = dat_q;

  // Interrupt identification in priority order
  always_comb begin
    iir = 8'h01;
    if (ier_q[2] & (oe_q | pe_q | fe_q | bi_q)) iir = 8'h06;
    else if (ier_q[0] & dr_q)                   iir = 8'h04;
    else if (ier_q[1] & thre_pend_q)            iir = 8'h02;
    else if (ier_q[3] & (|delta_q))             iir = 8'h00;
  end

  // Read data selection
  always_comb begin
    case (wb_addr_i)
      3'd0:    rd_val = dlab ? dll_q : rbr_q;
      3'd1:    rd_val = dlab ? dlm_q : {4'b0, ier_q};
      3'd2:    rd_val = iir;
      3'd3:    rd_val = lcr_q;
      3'd4:    rd_val = {3'b0, mcr_q};
      3'd5:    rd_val = lsr;
      3'd6:    rd_val = msr;
      default: rd_val = scr_q;
    endcase
  end

  // Baud counter next state: one 16x tick every DL clocks, frozen at DL=0
  always_comb begin
    tick   = 1'b0;
    bcnt_d = bcnt_q + 16'd1;
    if (wr_dll || wr_dlm || !dl_nz) begin
      bcnt_d = 16'd0;
    end else if (bcnt_q >= dl - 16'd1) begin
      bcnt_d = 16'd0;
      tick   = 1'b1;
    end
  end

  // Baud counter register
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) bcnt_q <= 16'd0;
    else          bcnt_q <= bcnt_d;
  end

  // Transmit FSM: start, data LSB first, optional parity, one or two stops
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_state_q <= S_IDLE;
      tx_sh_q    <= 8'h00;
      tx_bit_q   <= 3'd0;
      tx_tcnt_q  <= 4'd0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_out_q   <= 1'b1;
    end else if (tx_state_q == S_IDLE) begin
      if (tx_load) begin
        tx_state_q <= S_START;
        tx_sh_q    <= thr_q;
        tx_par_q   <= par_bit(thr_q, lcr_q[1:0], lcr_q[4], lcr_q[5]);
        tx_bit_q   <= 3'd0;
        tx_tcnt_q  <= 4'd0;
        tx_out_q   <= 1'b0;
      end
    end else if (tick) begin
      tx_tcnt_q <= tx_tcnt_q + 4'd1;
      if (tx_tcnt_q == 4'd15) begin
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            tx_out_q   <= tx_sh_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == last_bit) begin
              if (lcr_q[3]) begin
                tx_state_q <= S_PAR;
                tx_out_q   <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_out_q   <= 1'b1;
                tx_stop2_q <= lcr_q[2];
              end
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= tx_sh_q >> 1;
              tx_out_q <= tx_sh_q[1];
            end
          end
          S_PAR: begin
            tx_state_q <= S_STOP;
            tx_out_q   <= 1'b1;
            tx_stop2_q <= lcr_q[2];
          end
          S_STOP: begin
            if (tx_stop2_q) tx_stop2_q <= 1'b0;
            else            tx_state_q <= S_IDLE;
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  // RX synchroniser and edge-detect history
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], srx_pad_i};
      rx_prev_q <= rx_in;
    end
  end

  // Receive FSM: mid-bit sampling at the 8th tick, character strobe on stop
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_state_q <= S_IDLE;
      rx_sh_q    <= 8'h00;
      rx_bit_q   <= 3'd0;
      rx_tcnt_q  <= 4'd0;
      rx_par_q   <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_char_q  <= 8'h00;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_bi_q    <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      if (rx_state_q == S_IDLE) begin
        if (rx_prev_q && !rx_in && dl_nz) begin
          rx_state_q <= S_START;
          rx_sh_q    <= 8'h00;
          rx_bit_q   <= 3'd0;
          rx_tcnt_q  <= 4'd0;
          rx_par_q   <= 1'b0;
        end
      end else if (tick) begin
        rx_tcnt_q <= rx_tcnt_q + 4'd1;
        case (rx_state_q)
          S_START: begin
            if (rx_tcnt_q == 4'd7 && rx_in) rx_state_q <= S_IDLE;
            else if (rx_tcnt_q == 4'd15)    rx_state_q <= S_DATA;
          end
          S_DATA: begin
            if (rx_tcnt_q == 4'd7) rx_sh_q[rx_bit_q] <= rx_in;
            if (rx_tcnt_q == 4'd15) begin
              if (rx_bit_q == last_bit) rx_state_q <= lcr_q[3] ? S_PAR : S_STOP;
              else                      rx_bit_q   <= rx_bit_q + 3'd1;
            end
          end
          S_PAR: begin
            if (rx_tcnt_q == 4'd7)  rx_par_q   <= rx_in;
            if (rx_tcnt_q == 4'd15) rx_state_q <= S_STOP;
          end
          S_STOP: begin
            if (rx_tcnt_q == 4'd7) begin
              rx_state_q <= S_IDLE;
              rx_done_q  <= 1'b1;
              rx_char_q  <= rx_sh_q;
              rx_pe_q    <= lcr_q[3] &
                            (rx_par_q != par_bit(rx_sh_q, lcr_q[1:0], lcr_q[4], lcr_q[5]));
              rx_fe_q    <= ~rx_in;
              rx_bi_q    <= ~rx_in & (rx_sh_q == 8'h00) & (~lcr_q[3] | ~rx_par_q);
            end
          end
          default: rx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Register file, status flags, interrupt pending and read-data register
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lcr_q       <= 8'h03;
      ier_q       <= 4'h0;
      mcr_q       <= 5'h00;
      scr_q       <= 8'h00;
      dll_q       <= 8'h00;
      dlm_q       <= 8'h00;
      thr_q       <= 8'h00;
      thr_full_q  <= 1'b0;
      rbr_q       <= 8'h00;
      dr_q        <= 1'b0;
      oe_q        <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      bi_q        <= 1'b0;
      thre_pend_q <= 1'b0;
      mdm_q       <= 4'h0;
      delta_q     <= 4'h0;
      dat_q       <= 8'h00;
    end else begin
      if (wr_lcr) lcr_q <= wb_dat_i;
      if (wr_ier) ier_q <= wb_dat_i[3:0];
      if (wr_mcr) mcr_q <= wb_dat_i[4:0];
      if (wr_scr) scr_q <= wb_dat_i;
      if (wr_dll) dll_q <= wb_dat_i;
      if (wr_dlm) dlm_q <= wb_dat_i;

      if (wr_thr) begin
        thr_q      <= wb_dat_i;
        thr_full_q <= 1'b1;
      end else if (tx_load | fcr_abort) begin
        thr_full_q <= 1'b0;
      end

      if (rd_lsr) begin
        oe_q <= 1'b0;
        pe_q <= 1'b0;
        fe_q <= 1'b0;
        bi_q <= 1'b0;
      end
      if (fcr_clr) begin
        dr_q  <= 1'b0;
        rbr_q <= 8'h00;
      end else if (rd_rbr) begin
        dr_q <= 1'b0;
      end
      // A character completing in the same cycle as an RBR read replaces it
      if (rx_done_q) begin
        if (rx_accept) begin
          rbr_q <= rx_char_q;
          dr_q  <= 1'b1;
          if (rx_pe_q) pe_q <= 1'b1;
          if (rx_fe_q) fe_q <= 1'b1;
          if (rx_bi_q) bi_q <= 1'b1;
        end else begin
          oe_q <= 1'b1;
        end
      end

      if (wr_thr || (rd_iir && iir == 8'h02)) thre_pend_q <= 1'b0;
      if (thre_rise || (wr_ier && wb_dat_i[1] && !ier_q[1] && !thr_full_q))
        thre_pend_q <= 1'b1;

      mdm_q   <= mdm_cur;
      delta_q <= (rd_msr ? 4'h0 : delta_q) | new_delta;

      if (wb_re_i) dat_q <= rd_val;
    end
  end

endmodule

// File: tb/tb_uart16550_regs.sv
// tb_uart16550_regs: register map vectors plus serial, loopback, overrun,
// parity, modem-status and reset sequences for uart16550_regs.
module tb_uart16550_regs;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [2:0] wb_addr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i, wb_re_i;
  logic [3:0] modem_inputs;
  logic       stx_pad_o, srx_pad_i, rts_pad_o, dtr_pad_o, int_o;

  always #5 clk = ~clk;

  uart16550_regs dut (
    .clk          (clk),
    .wb_rst_i     (wb_rst_i),
    .wb_addr_i    (wb_addr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_we_i      (wb_we_i),
    .wb_re_i      (wb_re_i),
    .modem_inputs (modem_inputs),
    .stx_pad_o    (stx_pad_o),
    .srx_pad_i    (srx_pad_i),
    .rts_pad_o    (rts_pad_o),
    .dtr_pad_o    (dtr_pad_o),
    .int_o        (int_o)
  );

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdat;
    logic [7:0] exp;
    logic       exp_int;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb_q[$];   // expected read data, queued as each read is issued
  logic       bit_q[$];  // expected serial bits
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    wb_addr_i = a;
    wb_dat_i  = d;
    wb_we_i   = 1'b1;
    @(posedge clk);
    #1;
    wb_we_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string name);
    logic [7:0] e;
    sb_q.push_back(exp);
    wb_addr_i = a;
    wb_re_i   = 1'b1;
    @(posedge clk);
    #1;
    wb_re_i   = 1'b0;
    e = sb_q.pop_front();
    check(name, wb_dat_o, e);
  endtask

  task automatic wait_int(input int budget, input string name);
    int n;
    n = 0;
    while (int_o !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {7'b0, int_o}, 8'h01);
  endtask

  function automatic void add(input logic we, input logic [2:0] a, input logic [7:0] d,
                              input logic [7:0] exp, input logic ei);
    vec_t v;
    v.we = we; v.addr = a; v.wdat = d; v.exp = exp; v.exp_int = ei;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [9:0] frame;
    logic       b;

    wb_rst_i     = 1'b1;
    wb_addr_i    = 3'd0;
    wb_dat_i     = 8'h00;
    wb_we_i      = 1'b0;
    wb_re_i      = 1'b0;
    modem_inputs = 4'h0;
    srx_pad_i    = 1'b1;
    idle(3);
    check("rst_stx", {7'b0, stx_pad_o}, 8'h01);
    check("rst_int", {7'b0, int_o}, 8'h00);
    check("rst_dat", wb_dat_o, 8'h00);
    wb_rst_i = 1'b0;
    idle(2);

    // Register-map vectors: {we, addr, wdata, expected read, expected int_o}
    add(0, 3, 8'h00, 8'h03, 0);
    add(0, 5, 8'h00, 8'h60, 0);
    add(0, 2, 8'h00, 8'h01, 0);
    add(0, 4, 8'h00, 8'h00, 0);
    add(0, 6, 8'h00, 8'h00, 0);
    add(1, 7, 8'hA5, 8'h00, 0);
    add(1, 3, 8'h83, 8'h00, 0);
    add(1, 0, 8'h01, 8'h00, 0);
    add(1, 1, 8'h00, 8'h00, 0);
    add(0, 0, 8'h00, 8'h01, 0);
    add(0, 1, 8'h00, 8'h00, 0);
    add(0, 3, 8'h00, 8'h83, 0);
    add(1, 3, 8'h03, 8'h00, 0);
    add(0, 7, 8'h00, 8'hA5, 0);
    add(0, 0, 8'h00, 8'h00, 0);
    add(1, 4, 8'hE3, 8'h00, 0);
    add(0, 4, 8'h00, 8'h03, 0);
    add(1, 1, 8'h02, 8'h00, 1);
    add(0, 1, 8'h00, 8'h02, 1);
    add(0, 2, 8'h00, 8'h02, 0);
    add(0, 2, 8'h00, 8'h01, 0);
    add(1, 1, 8'h00, 8'h00, 0);
    add(1, 4, 8'h00, 8'h00, 0);
    add(0, 1, 8'h00, 8'h00, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) bus_write(tbl[i].addr, tbl[i].wdat);
      else           bus_read(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_int", i), {7'b0, int_o}, {7'b0, tbl[i].exp_int});
    end

    // Modem-control pads follow MCR[1:0]
    bus_write(4, 8'h03);
    check("rts_on", {7'b0, rts_pad_o}, 8'h01);
    check("dtr_on", {7'b0, dtr_pad_o}, 8'h01);
    bus_write(4, 8'h00);

    // 8N1 transmit of 0x55 at DL=1: every bit lasts 16 clocks
    bus_write(0, 8'h55);
    bus_read(5, 8'h00, "lsr_thr_full");
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) bit_q.push_back(frame[i]);
    for (int c = 1; c <= 165; c++) begin
      if (c == 50) bus_read(5, 8'h20, "lsr_shifting");
      else         idle(1);
      if (c % 16 == 8 && bit_q.size() > 0) begin
        b = bit_q.pop_front();
        check($sformatf("stx_bit%0d", c / 16), {7'b0, stx_pad_o}, {7'b0, b});
      end
    end
    bus_read(5, 8'h60, "lsr_temt");

    // Break forces the line low
    bus_write(3, 8'h43);
    check("break_low", {7'b0, stx_pad_o}, 8'h00);
    bus_write(3, 8'h03);
    check("break_off", {7'b0, stx_pad_o}, 8'h01);

    // Loopback: pads parked, RX fed from TX
    bus_write(4, 8'h13);
    check("lb_stx", {7'b0, stx_pad_o}, 8'h01);
    check("lb_rts", {7'b0, rts_pad_o}, 8'h00);
    check("lb_dtr", {7'b0, dtr_pad_o}, 8'h00);
    bus_write(4, 8'h10);
    bus_write(1, 8'h01);
    bus_write(0, 8'hC3);
    wait_int(400, "rda_int");
    idle(20);
    bus_read(5, 8'h61, "lb_lsr");
    bus_read(2, 8'h04, "lb_iir");
    check("lb_int_hi", {7'b0, int_o}, 8'h01);
    bus_read(0, 8'hC3, "lb_rbr");
    check("lb_int_lo", {7'b0, int_o}, 8'h00);
    bus_read(5, 8'h60, "lb_lsr_empty");

    // Overrun: second character arrives while the first is unread
    bus_write(1, 8'h00);
    bus_write(0, 8'h3C);
    bus_write(0, 8'h81);
    idle(400);
    bus_read(5, 8'h63, "ovr_lsr");
    bus_read(5, 8'h61, "ovr_lsr2");
    bus_read(0, 8'h3C, "ovr_rbr");
    bus_read(5, 8'h60, "ovr_lsr3");

    // 7 data bits with even parity: upper data bit dropped, no parity error
    bus_write(3, 8'h1A);
    bus_write(0, 8'hFF);
    idle(400);
    bus_read(5, 8'h61, "p7_lsr");
    bus_read(0, 8'h7F, "p7_rbr");
    bus_write(3, 8'h03);

    // FCR bit 1 discards a received character
    bus_write(0, 8'h5A);
    idle(400);
    bus_read(5, 8'h61, "fcr_lsr_pre");
    bus_write(2, 8'h02);
    bus_read(5, 8'h60, "fcr_lsr_post");

    // Modem status: loopback MCR toggles left DCTS/DDSR pending
    bus_write(4, 8'h00);
    idle(2);
    bus_read(6, 8'h03, "msr_lb_delta");
    bus_write(1, 8'h08);
    modem_inputs = 4'b1000;
    idle(2);
    bus_read(2, 8'h00, "msr_iir");
    check("msr_int", {7'b0, int_o}, 8'h01);
    bus_read(6, 8'h11, "msr_dcts");
    bus_read(6, 8'h10, "msr_clear");
    bus_read(2, 8'h01, "msr_iir_none");
    check("msr_int_lo", {7'b0, int_o}, 8'h00);

    // Reset in the middle of a frame returns everything to idle at once
    bus_write(1, 8'h00);
    bus_write(0, 8'h00);
    idle(30);
    check("mid_stx_low", {7'b0, stx_pad_o}, 8'h00);
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_stx", {7'b0, stx_pad_o}, 8'h01);
    idle(2);
    wb_rst_i = 1'b0;
    idle(1);
    bus_read(5, 8'h60, "mid_rst_lsr");
    bus_read(3, 8'h03, "mid_rst_lcr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
